number_display: RTL and testbench
=================================

# number_display

Read-side counterpart of the calculator's number-entry logic: takes the two 14-bit operands (0–9999) produced by the slider-entry block, selects one, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed 4-digit common-anode seven-segment display. Sits between the entry/arithmetic logic and the board display pins. Out-of-range values (>9999) are shown as four dashes.

## Interface

- `REFRESH_DIV`, 50000: clock cycles each digit stays lit (1 kHz digit rate at 50 MHz); minimum 2.
- `BLANK_LEADING`, 1: 1 = blank leading zeros (units digit never blanked); 0 = show all four digits.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `number_1`  in  14  operand 1, binary.
- `number_2`  in  14  operand 2, binary.
- `show_select`  in  1  0 = display `number_1`, 1 = display `number_2`.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low one-hot; `an[0]` = units, `an[3]` = thousands.
- `bcd`  out  16  registered digits {thousands,hundreds,tens,units}, 4 bits each.
- `ovf`  out  1  registered: displayed value >9999.
- `busy`  out  1  high while a conversion is in progress.

## Operation

- Source: `src = show_select ? number_2 : number_1` (combinational).
- Converter FSM, states IDLE, CONV:
  - IDLE: if `src != last_src`, capture `src` into the 14-bit shift register and `last_src`, clear the 16-bit BCD scratch, clear the 4-bit step counter.
    - Captured value ≤9999: go to CONV.
    - Captured value >9999: stay IDLE. Set `ovf`=1 and `bcd`=16'h0000 on the same edge.
    - Otherwise remain IDLE.
  - CONV: once per cycle, add 3 to each scratch nibble ≥5, then shift {scratch, shreg} left by 1.
    - On the 14th step, write the shifted scratch to `bcd`, clear `ovf`, and go to IDLE.
- Input changes during CONV are ignored. On return to IDLE, `src` is compared against `last_src`, so the latest value is always converted eventually.
- `busy` = (state == CONV).
- Scanner: the refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index advances 0→1→2→3→0. `an` = ~(1 << index).
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - dash=0111111, blank=1111111.
- Segment selection, in priority order:
  - `ovf`=1: dash on every digit.
  - Else, `BLANK_LEADING`=1 and index>0 and every `bcd` digit at position ≥index is 0: blank.
  - Else: decode of the `bcd` digit at index.
- Scanner runs continuously, independent of the converter. `seg` and `an` are registered.

## Timing

- Reset values:
  - State IDLE; `last_src`=0, shift register=0, scratch=0, step counter=0.
  - `bcd`=16'h0000, `ovf`=0, `busy`=0.
  - Refresh counter=0, index=0.
  - `an`=4'b1110, `seg`=1000000 (units "0").
- Conversion latency:
  - `src` change is captured at edge k; `busy` is high after edge k.
  - Steps occur at edges k+1..k+14. `bcd` updates and `busy` falls at edge k+14.
- Overflow latency: `ovf` and dashes take effect at the capture edge k; `busy` stays 0.
- Back-to-back: one IDLE cycle minimum between conversions. A new capture can occur at edge k+15.
- Scan: each digit is active for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- `seg`/`an` reflect a new `bcd` or `ovf` within one cycle of the register update; there is no frame-boundary hold.
- Reset mid-conversion: the conversion aborts immediately, all registers return to reset values, and the partial result is never written to `bcd`.
- `show_select` toggle behaves as a `src` change; same latency.

## Test plan

- Reset release with `number_1`=0, `show_select`=0:
  - `bcd`=0000, `an`=1110, `seg`=1000000, `busy`=0.
  - With `BLANK_LEADING`=1, digits 1–3 read 1111111 across the frame.
- `number_1` 0→1234:
  - `busy` high for exactly 14 cycles.
  - `bcd`=16'h1234 at edge k+14.
  - Scan, with `REFRESH_DIV`=4, shows 4,3,2,1 decodes on `an`=1110,1101,1011,0111 at 4 cycles each.
- `number_2`=9999, then `show_select` 0→1: after 14 steps `bcd`=16'h9999. Then `number_2`=0 gives `bcd`=0000 and leading blanks.
- `number_1`=10000: `ovf`=1 at the capture edge, `busy` stays 0, all digits show 0111111. Then `number_1`=7 gives `ovf`=0 and units "7" after 14 cycles.
- `number_1` changes 100→205 on step 5 of a running conversion: first result `bcd`=0100, then a second conversion starts one cycle later, ending with `bcd`=0205.
- `rst` asserted on conversion step 7 of value 4321 (previous `bcd`=0042): outputs asynchronously return to reset values, and `bcd`=0000, not a partial value.

Source files
------------

// File: rtl/number_display_if.sv
// number_display_if
//   Bundles the operand inputs and display outputs of number_display.
//   master: the side that supplies operands and observes the display
//           (entry logic or testbench).
//   slave : the display block itself.
//   Signals:
//     number_1, number_2 [13:0] : binary operands (0..9999 valid)
//     show_select               : 0 = number_1, 1 = number_2
//     seg [6:0]                 : {g,f,e,d,c,b,a}, active-low
//     an  [3:0]                 : digit anodes, active-low one-hot
//     bcd [15:0]                : {thousands,hundreds,tens,units}
//     ovf                       : displayed value > 9999
//     busy                      : conversion in progress
interface number_display_if;
  logic [13:0] number_1;
  logic [13:0] number_2;
  logic        show_select;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        ovf;
  logic        busy;

  modport master (
    output number_1, number_2, show_select,
    input  seg, an, bcd, ovf, busy
  );

  modport slave (
    input  number_1, number_2, show_select,
    output seg, an, bcd, ovf, busy
  );
endinterface

// File: rtl/number_display.sv
// number_display
//   Selects one of two 14-bit operands, converts it to four BCD digits with
//   a sequential double-dabble engine (14 steps), and scans the result onto
//   a 4-digit common-anode seven-segment display. Values above 9999 are
//   flagged as overflow and shown as four dashes.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous reset, active-high
//     disp : number_display_if.slave (operands in; seg/an/bcd/ovf/busy out)
//   Parameters:
//     REFRESH_DIV   : cycles each digit stays lit (>= 2)
//     BLANK_LEADING : 1 = blank leading zeros (units never blanked)
module number_display #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  number_display_if.slave   disp
);

  localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  // ---------------------------------------------------------------- converter
  state_t      r_state, w_state_nxt;
  logic [13:0] w_src;
  logic [13:0] r_last_src, w_last_src_nxt;
  logic [13:0] r_shreg, w_shreg_nxt;
  logic [15:0] r_scratch, w_scratch_nxt;
  logic [15:0] w_adj;
  logic [29:0] w_shifted;
  logic [3:0]  r_step, w_step_nxt;
  logic [15:0] r_bcd, w_bcd_nxt;
  logic        r_ovf, w_ovf_nxt;

  assign w_src = disp.show_select ? disp.number_2 : disp.number_1;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_scratch[4*i +: 4];
    end
  end

  assign w_shifted = {w_adj, r_shreg} << 1;

  always_comb begin
    w_state_nxt    = r_state;
    w_last_src_nxt = r_last_src;
    w_shreg_nxt    = r_shreg;
    w_scratch_nxt  = r_scratch;
    w_step_nxt     = r_step;
    w_bcd_nxt      = r_bcd;
    w_ovf_nxt      = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_src != r_last_src) begin
          w_last_src_nxt = w_src;
          w_shreg_nxt    = w_src;
          w_scratch_nxt  = '0;
          w_step_nxt     = '0;
          // Overflow resolves on the capture edge; no conversion is run.
          if (w_src > 14'd9999) begin
            w_ovf_nxt = 1'b1;
            w_bcd_nxt = '0;
          end else begin
            w_state_nxt = S_CONV;
          end
        end
      end
      S_CONV: begin
        w_scratch_nxt = w_shifted[29:14];
        w_shreg_nxt   = w_shifted[13:0];
        w_step_nxt    = r_step + 4'd1;
        if (r_step == 4'd13) begin
          w_bcd_nxt   = w_shifted[29:14];
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_src <= '0;
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_step     <= '0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_src <= w_last_src_nxt;
      r_shreg    <= w_shreg_nxt;
      r_scratch  <= w_scratch_nxt;
      r_step     <= w_step_nxt;
      r_bcd      <= w_bcd_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // ------------------------------------------------------------------ scanner
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic             w_wrap;
  logic             w_lead_zero;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_nxt;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

  // seg/an are computed from the next index and next bcd/ovf so that the
  // registered pair is always mutually consistent and tracks results with
  // no extra lag.
  always_comb begin
    w_lead_zero = 1'b1;
    for (int unsigned p = 0; p < 4; p++) begin
      if ((p >= {30'd0, w_idx_nxt}) && (w_bcd_nxt[4*p +: 4] != 4'd0))
        w_lead_zero = 1'b0;
    end
  end

  assign w_digit = w_bcd_nxt[{w_idx_nxt, 2'b00} +: 4];

  always_comb begin
    w_seg_nxt = seg7(w_digit);
    if (w_ovf_nxt)
      w_seg_nxt = SEG_DASH;
    else if (BLANK_LEADING && (w_idx_nxt != 2'd0) && w_lead_zero)
      w_seg_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_seg <= 7'b1000000;
      r_an  <= 4'b1110;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_idx <= w_idx_nxt;
      r_seg <= w_seg_nxt;
      r_an  <= ~(4'b0001 << w_idx_nxt);
    end
  end

  // ------------------------------------------------------------------ outputs
  assign disp.seg  = r_seg;
  assign disp.an   = r_an;
  assign disp.bcd  = r_bcd;
  assign disp.ovf  = r_ovf;
  assign disp.busy = (r_state == S_CONV);

endmodule

// File: tb/tb_number_display.sv
module tb_number_display;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  number_display_if ifc();

  number_display #(
    .REFRESH_DIV  (DIV),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .disp(ifc.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: last captured source, value currently shown, overflow.
  int m_last;
  int m_val;
  bit m_ovf;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit ovf, input int idx);
    int pw = 1;
    if (ovf) return DASH;
    for (int i = 0; i < idx; i++) pw = pw * 10;
    if (idx > 0 && v < pw) return BLANK;
    return seg_tab[(v / pw) % 10];
  endfunction

  function automatic int src_now();
    return ifc.show_select ? int'(ifc.number_2) : int'(ifc.number_1);
  endfunction

  task automatic check_display(input string tag);
    int idx = -1;
    logic [3:0] pat;
    for (int i = 0; i < 4; i++) begin
      pat = ~(4'b0001 << i);
      if (ifc.an === pat) idx = i;
    end
    chk({tag, "_an_onehot"}, 32'(idx >= 0), 32'd1);
    if (idx >= 0) chk({tag, "_seg"}, 32'(ifc.seg), 32'(exp_seg(m_val, m_ovf, idx)));
  endtask

  // Observe one full frame starting at a digit boundary: each digit must be
  // held exactly DIV cycles, in ascending order, with the modelled segments.
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    logic [3:0] pat;
    int start = -1;
    bit found = 0;
    for (int c = 0; c < 4 * DIV + 2 && !found; c++) begin
      prev = ifc.an;
      @(negedge clk);
      if (ifc.an !== prev) found = 1;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    if (!found) return;
    for (int i = 0; i < 4; i++) begin
      pat = ~(4'b0001 << i);
      if (ifc.an === pat) start = i;
    end
    chk({tag, "_start_valid"}, 32'(start >= 0), 32'd1);
    if (start < 0) return;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DIV; c++) begin
        pat = ~(4'b0001 << ((start + d) % 4));
        chk({tag, "_an"}, 32'(ifc.an), 32'(pat));
        chk({tag, "_seg"}, 32'(ifc.seg), 32'(exp_seg(m_val, m_ovf, (start + d) % 4)));
        @(negedge clk);
      end
    end
  endtask

  // Count negedges on which busy is seen high, starting at the current one.
  task automatic wait_conv(output int cnt);
    cnt = 0;
    for (int c = 0; c < 40 && ifc.busy === 1'b1; c++) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Inputs were just changed at a negedge so that src differs from m_last.
  task automatic conv(input string tag);
    int v;
    int cnt;
    v = src_now();
    @(negedge clk);
    m_last = v;
    if (v > 9999) begin
      chk({tag, "_ovf"}, 32'(ifc.ovf), 32'd1);
      chk({tag, "_ovf_busy"}, 32'(ifc.busy), 32'd0);
      chk({tag, "_ovf_bcd"}, 32'(ifc.bcd), 32'd0);
      m_ovf = 1;
      m_val = 0;
      check_display(tag);
      @(negedge clk);
      chk({tag, "_ovf_busy2"}, 32'(ifc.busy), 32'd0);
    end else begin
      chk({tag, "_busy"}, 32'(ifc.busy), 32'd1);
      check_display({tag, "_during"});
      wait_conv(cnt);
      chk({tag, "_latency"}, 32'(cnt), 32'd14);
      chk({tag, "_bcd"}, 32'(ifc.bcd), 32'(to_bcd(v)));
      chk({tag, "_ovf_clr"}, 32'(ifc.ovf), 32'd0);
      m_val = v;
      m_ovf = 0;
      check_display(tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    rst = 1'b1;
    ifc.number_1 = '0;
    ifc.number_2 = '0;
    ifc.show_select = 1'b0;
    m_last = 0; m_val = 0; m_ovf = 0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(ifc.bcd), 32'h0);
    chk("rst_an", 32'(ifc.an), 32'hE);
    chk("rst_seg", 32'(ifc.seg), 32'h40);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_ovf", 32'(ifc.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(ifc.busy), 32'd0);
    check_frame("zero_frame");

    ifc.number_1 = 14'd1234;
    conv("n1234");
    check_frame("f1234");

    ifc.number_2 = 14'd9999;
    @(negedge clk);
    chk("unselected_no_capture", 32'(ifc.busy), 32'd0);
    ifc.show_select = 1'b1;
    conv("n9999");
    check_frame("f9999");
    ifc.number_2 = 14'd0;
    conv("n2_zero");
    check_frame("f_zero");

    ifc.show_select = 1'b0;
    conv("sel_back");

    ifc.number_1 = 14'd10000;
    conv("ovf10000");
    check_frame("f_dash");
    ifc.number_1 = 14'd7;
    conv("n7");
    check_frame("f7");

    // Input change while a conversion is running.
    ifc.number_1 = 14'd100;
    @(negedge clk);
    chk("mid_busy", 32'(ifc.busy), 32'd1);
    repeat (4) @(negedge clk);
    ifc.number_1 = 14'd205;
    wait_conv(cnt);
    chk("mid_first_len", 32'(cnt), 32'd10);
    chk("mid_first_bcd", 32'(ifc.bcd), 32'h0100);
    chk("mid_idle_gap", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    chk("mid_second_start", 32'(ifc.busy), 32'd1);
    m_last = 205;
    wait_conv(cnt);
    chk("mid_second_len", 32'(cnt), 32'd14);
    chk("mid_second_bcd", 32'(ifc.bcd), 32'h0205);
    m_val = 205; m_ovf = 0;
    check_display("mid_disp");

    // Randomized operand/select traffic.
    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 3);
      ifc.number_1 = (r == 0) ? 14'($urandom_range(10000, 16383)) : 14'($urandom_range(0, 9999));
      r = $urandom_range(0, 3);
      ifc.number_2 = (r == 0) ? 14'($urandom_range(10000, 16383)) : 14'($urandom_range(0, 9999));
      if ($urandom_range(0, 1) == 1) ifc.show_select = ~ifc.show_select;
      if (src_now() != m_last) begin
        conv("rand");
      end else begin
        @(negedge clk);
        chk("rand_no_capture", 32'(ifc.busy), 32'd0);
      end
    end

    // Reset during a conversion.
    ifc.show_select = 1'b0;
    ifc.number_1 = 14'd42;
    if (src_now() != m_last) conv("pre42");
    chk("pre42_bcd", 32'(ifc.bcd), 32'h0042);
    ifc.number_1 = 14'd4321;
    @(negedge clk);
    chk("r4321_busy", 32'(ifc.busy), 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_bcd", 32'(ifc.bcd), 32'h0);
    chk("arst_busy", 32'(ifc.busy), 32'd0);
    chk("arst_ovf", 32'(ifc.ovf), 32'd0);
    chk("arst_an", 32'(ifc.an), 32'hE);
    chk("arst_seg", 32'(ifc.seg), 32'h40);
    ifc.number_1 = 14'd0;
    @(negedge clk);
    rst = 1'b0;
    m_last = 0; m_val = 0; m_ovf = 0;
    repeat (20) @(negedge clk);
    chk("after_rst_bcd", 32'(ifc.bcd), 32'h0);
    chk("after_rst_busy", 32'(ifc.busy), 32'd0);
    check_frame("after_rst_frame");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
